// File: rtl/seq_recorder_if.sv
// Record stream from seq_recorder to its consumer.
// The recorder drives rec_o/valid_o on the master modport, and the consumer returns ready_i on the slave modport.
interface seq_recorder_if #(
  parameter int dw = 4,
  parameter int cw = 12
);
  logic [dw+cw-1:0] rec_o;
  logic             valid_o;
  logic             ready_i;

  modport master (output rec_o, output valid_o, input ready_i);
  modport slave  (input rec_o, input valid_o, output ready_i);
endinterface

// File: rtl/seq_recorder.sv
// Run-length recorder: compresses an armed input bus into {value, count} records held in a first-word-fall-through FIFO.
// Define SEQ_RECORDER_STOP_EN to append a {0,0} terminator record after every recording.
module seq_recorder #(
  parameter int dw = 4,
  parameter int cw = 12,
  parameter int fd = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [dw-1:0] data_i,
  input  logic          arm,
  seq_recorder_if.master rec_if,
  output logic          busy,
  output logic          overflow
);

  localparam int aw = $clog2(fd);
  localparam int rw = dw + cw;
  localparam logic [cw-1:0] cnt_max  = '1;
  localparam logic [aw:0]   occ_full = (aw+1)'(fd);

  typedef enum logic [1:0] {
    IDLE,
    RUN
`ifdef SEQ_RECORDER_STOP_EN
    , TERM
`endif
  } state_e;

  state_e        state_q;
  logic [dw-1:0] cur_q;
  logic [cw-1:0] cnt_q;
  logic          ovf_q;

  logic [rw-1:0] mem_q [fd];
  logic [aw-1:0] wr_q, rd_q;
  logic [aw:0]   occ_q;

  logic          push;
  logic [rw-1:0] push_rec;
  logic          same_run;
  logic          full, empty, pop, accept, drop;

  assign same_run = (data_i == cur_q) && (cnt_q != cnt_max);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    push     = 1'b0;
    push_rec = '0;
    case (state_q)
      RUN: begin
        if (!arm || !same_run) begin
          push     = 1'b1;
          push_rec = {cur_q, cnt_q};
        end
      end
`ifdef SEQ_RECORDER_STOP_EN
      TERM: begin
        push     = 1'b1;
        push_rec = '0;
      end
`endif
      default: ;
    endcase
  end

  assign full   = (occ_q == occ_full);
  assign empty  = (occ_q == '0);
  assign pop    = !empty && rec_if.ready_i;
  // A pop at the same edge frees a slot, so a push into a full FIFO still lands.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // NOTE: registers use <= so every update sees the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q <= RUN;
            cur_q   <= data_i;
            cnt_q   <= cw'(1);
            ovf_q   <= 1'b0;
          end
        end
        RUN: begin
          if (arm) begin
            if (same_run) begin
              cnt_q <= cnt_q + cw'(1);
            end else begin
              cur_q <= data_i;
              cnt_q <= cw'(1);
            end
          end else begin
`ifdef SEQ_RECORDER_STOP_EN
            state_q <= TERM;
`else
            state_q <= IDLE;
`endif
          end
        end
`ifdef SEQ_RECORDER_STOP_EN
        TERM: state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (accept) wr_q <= wr_q + aw'(1);
      if (pop)    rd_q <= rd_q + aw'(1);
      case ({accept, pop})
        2'b10:   occ_q <= occ_q + (aw+1)'(1);
        2'b01:   occ_q <= occ_q - (aw+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: the record storage has no reset; the pointers and occupancy alone decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= push_rec;
  end

  assign rec_if.valid_o = !empty;
  assign rec_if.rec_o   = empty ? '0 : mem_q[rd_q];
  assign busy           = (state_q != IDLE) || !empty;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_seq_recorder.sv
// Randomised scoreboard bench for seq_recorder: a record-level model fills an expected queue, and a monitor drains it on each handshake.
module tb_seq_recorder;
  localparam int DW = 4;
  localparam int CW = 4;
  localparam int FD = 4;
  localparam int RW = DW + CW;
  localparam int MAXRUN = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_i;
  logic          arm;
  logic          busy, overflow;

  seq_recorder_if #(.dw(DW), .cw(CW)) rec_if ();

  seq_recorder #(.dw(DW), .cw(CW), .fd(FD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_i   (data_i),
    .arm      (arm),
    .rec_if   (rec_if),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_pops = 0;
  bit mon_en = 0;

  // Model: run tracker, FIFO occupancy, and the records expected on the output.
  logic [RW-1:0] exp_q[$];
  bit            m_run, m_term, m_ovf;
  int            m_cnt, m_occ;
  logic [DW-1:0] m_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_run = 0; m_term = 0; m_ovf = 0;
    m_cnt = 0; m_occ = 0; m_cur = '0;
  endtask

  // Apply one cycle of stimulus and predict the effect of the next edge.
  task automatic step(input bit a, input logic [DW-1:0] d, input bit r);
    bit run = m_run, term = m_term, ovf = m_ovf;
    int cnt = m_cnt, occ = m_occ;
    logic [DW-1:0] cur = m_cur;
    bit push = 0, pop;
    logic [RW-1:0] rec = '0;
    arm = a; data_i = d; rec_if.ready_i = r;
    pop = (occ > 0) && r;
    if (term) begin
      push = 1; rec = '0; term = 0;
    end else if (!run) begin
      if (a) begin run = 1; cur = d; cnt = 1; ovf = 0; end
    end else if (a) begin
      if (d == cur && cnt < MAXRUN) cnt++;
      else begin push = 1; rec = {cur, CW'(cnt)}; cur = d; cnt = 1; end
    end else begin
      push = 1; rec = {cur, CW'(cnt)}; run = 0;
`ifdef SEQ_RECORDER_STOP_EN
      term = 1;
`endif
    end
    if (push) begin
      if (occ < FD || pop) begin exp_q.push_back(rec); occ++; end
      else ovf = 1;
    end
    if (pop) occ--;
    @(posedge clk);
    #1;
    m_run = run; m_term = term; m_ovf = ovf; m_cnt = cnt; m_occ = occ; m_cur = cur;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (busy || m_occ > 0); i++) step(1'b0, '0, 1'b1);
    check("drain_busy", busy, 0);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  bit            held_v = 0;
  logic [RW-1:0] held_rec;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_v = 0;
    end else if (mon_en) begin
      check("valid_o", rec_if.valid_o, m_occ > 0);
      check("busy", busy, m_run || m_term || m_occ > 0);
      check("overflow", overflow, m_ovf);
      if (held_v) check("rec_hold", rec_if.rec_o, held_rec);
      if (rec_if.valid_o && rec_if.ready_i) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rec_unexpected: got %0h expected none", rec_if.rec_o);
        end else begin
          check("rec_o", rec_if.rec_o, exp_q.pop_front());
        end
      end
      held_v   = rec_if.valid_o && !rec_if.ready_i;
      held_rec = rec_if.rec_o;
    end
  end

  initial begin
    logic [DW-1:0] t1_data [5] = '{4'h9, 4'h9, 4'h9, 4'hC, 4'hC};
    int base;
    bit ra;
    logic [DW-1:0] rd;
    rst_n = 1'b0; arm = 1'b0; data_i = '0; rec_if.ready_i = 1'b0;
    model_reset();
    #3;
    check("reset_rec_o", rec_if.rec_o, 0);
    check("reset_valid_o", rec_if.valid_o, 0);
    check("reset_busy", busy, 0);
    check("reset_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1;

    // Basic run-length compression
    foreach (t1_data[i]) step(1'b1, t1_data[i], 1'b1);
    step(1'b0, '0, 1'b1);
`ifdef SEQ_RECORDER_STOP_EN
    step(1'b1, 4'hA, 1'b1);
`endif
    drain();
    check("t1_overflow", overflow, 0);

    // Saturation splits a long run
    repeat (20) step(1'b1, 4'h5, 1'b1);
    step(1'b0, '0, 1'b1);
    drain();

    // Backpressure with overflow
    for (int i = 0; i < 10; i++) step(1'b1, DW'(i % 2), 1'b0);
    check("t3_overflow_set", overflow, 1);
    step(1'b0, '0, 1'b0);
    base = n_pops;
    drain();
`ifdef SEQ_RECORDER_STOP_EN
    check("t3_drained", n_pops - base, 5);
`else
    check("t3_drained", n_pops - base, 4);
`endif

    // Full FIFO with simultaneous push and pop
    base = n_pops;
    for (int i = 0; i < 5; i++) step(1'b1, DW'(i % 2), 1'b0);
    step(1'b1, 4'h7, 1'b1);
    step(1'b0, '0, 1'b1);
    drain();
    check("t4_overflow", overflow, 0);
`ifdef SEQ_RECORDER_STOP_EN
    check("t4_records", n_pops - base, 7);
`else
    check("t4_records", n_pops - base, 6);
`endif

    // Asynchronous reset mid-run
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    check("t5_queued", rec_if.valid_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rec_o", rec_if.rec_o, 0);
    check("t5_valid_o", rec_if.valid_o, 0);
    check("t5_busy", busy, 0);
    check("t5_overflow", overflow, 0);
    model_reset();
    #1 rst_n = 1'b1;
    repeat (3) step(1'b0, 4'h5, 1'b1);
    check("t5_idle", busy, 0);

    // Randomised traffic
    ra = 1'b0; rd = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) ra = !ra;
      if ($urandom_range(0, 3) == 0) rd = DW'($urandom_range(0, 3));
      step(ra, rd, $urandom_range(0, 3) != 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
